// File: rtl/clint_timer_pkg.sv
// Shared CLINT definitions: register offsets, reset constants, interrupt
// cause codes for the trap logic, and the address decode helper.
package clint_timer_pkg;

   // Byte offsets within the CLINT window
   localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

   // Size of the window the top level decodes for this block (64 KiB)
   localparam int unsigned CLINT_WINDOW_BYTES = 32'h0001_0000;

   // mtimecmp powers up at the maximum so no timer interrupt fires early
   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   // mcause values with the interrupt bit set
   localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
   localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;

   // Decoded register targeted by a bus access
   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_MSIP,
      SEL_CMP_LO,
      SEL_CMP_HI,
      SEL_TIME_LO,
      SEL_TIME_HI
   } reg_sel_e;

   // Misaligned or unmapped offsets decode to SEL_NONE
   function automatic reg_sel_e decode_offset(input logic [15:0] addr);
      reg_sel_e sel;
      sel = SEL_NONE;
      if (addr[1:0] == 2'b00) begin
         case (addr)
            CLINT_MSIP_OFF:        sel = SEL_MSIP;
            CLINT_MTIMECMP_LO_OFF: sel = SEL_CMP_LO;
            CLINT_MTIMECMP_HI_OFF: sel = SEL_CMP_HI;
            CLINT_MTIME_LO_OFF:    sel = SEL_TIME_LO;
            CLINT_MTIME_HI_OFF:    sel = SEL_TIME_HI;
            default:               sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

   // Byte-granular merge of write data into an existing 32-bit word
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Data-memory bus slice seen by the CLINT.
// Handshake: a request is transferred in every cycle where bus_valid=1 and
// bus_ready=1; bus_ready is held at 1 by this slave, so every valid request
// is accepted in its own cycle. Exactly one response follows in the next
// cycle as a one-cycle bus_rvalid pulse carrying bus_rdata and bus_err.
interface clint_timer_if;
   logic        bus_valid;
   logic        bus_write;
   logic [15:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;
   logic        bus_err;

   modport master (
      output bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ready, bus_rdata, bus_rvalid, bus_err
   );

   modport slave (
      input  bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb,
      output bus_ready, bus_rdata, bus_rvalid, bus_err
   );
endinterface

// File: rtl/clint_prescaler.sv
// Divides clk down to the mtime increment rate: tick is high for one cycle
// out of every PRESCALE cycles (every cycle when PRESCALE=1).
module clint_prescaler #(
   parameter int PRESCALE   = 1,   // must be >= 1
   parameter int PRESCALE_W = 16   // PRESCALE-1 must fit
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

   logic [PRESCALE_W-1:0] count;

   assign tick = (count == LAST);

   // Count 0..PRESCALE-1, wrapping on the tick cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: machine timer (mtime/mtimecmp) and software
// interrupt register (msip), driving MTIP/MSIP levels into the CSR file.
module clint_timer
   import clint_timer_pkg::*;
#(
   parameter int PRESCALE   = 1,
   parameter int PRESCALE_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   clint_timer_if.slave  bus,
   output logic          timer_interrupt,
   output logic          software_interrupt
);

   logic        tick;
   logic        msip;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;

   logic        msip_d;
   logic [63:0] mtime_d;
   logic [63:0] mtimecmp_d;
   logic [31:0] rdata_d;

   reg_sel_e    sel;
   logic        addr_ok;
   logic        wr_en;
   logic        rd_en;

   clint_prescaler #(
      .PRESCALE   (PRESCALE),
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Never stalls
   assign bus.bus_ready = 1'b1;

   // Decode the request; an all-zero strobe write is accepted but changes nothing
   always_comb begin
      sel     = decode_offset(bus.bus_addr);
      addr_ok = (sel != SEL_NONE);
      wr_en   = bus.bus_valid & bus.bus_write & addr_ok & (|bus.bus_wstrb);
      rd_en   = bus.bus_valid & ~bus.bus_write & addr_ok;
   end

   // Next state: a write to either mtime half replaces that cycle's increment
   always_comb begin
      msip_d     = msip;
      mtimecmp_d = mtimecmp;
      mtime_d    = tick ? (mtime + 64'd1) : mtime;
      if (wr_en) begin
         case (sel)
            SEL_MSIP: begin
               if (bus.bus_wstrb[0]) msip_d = bus.bus_wdata[0];
            end
            SEL_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp[31:0], bus.bus_wdata, bus.bus_wstrb);
            SEL_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp[63:32], bus.bus_wdata, bus.bus_wstrb);
            SEL_TIME_LO: mtime_d = {mtime[63:32], merge_bytes(mtime[31:0], bus.bus_wdata, bus.bus_wstrb)};
            SEL_TIME_HI: mtime_d = {merge_bytes(mtime[63:32], bus.bus_wdata, bus.bus_wstrb), mtime[31:0]};
            default: ;
         endcase
      end
   end

   // Read mux on current (pre-update) register values; writes and errors return 0
   always_comb begin
      rdata_d = '0;
      if (rd_en) begin
         case (sel)
            SEL_MSIP:    rdata_d = {31'd0, msip};
            SEL_CMP_LO:  rdata_d = mtimecmp[31:0];
            SEL_CMP_HI:  rdata_d = mtimecmp[63:32];
            SEL_TIME_LO: rdata_d = mtime[31:0];
            SEL_TIME_HI: rdata_d = mtime[63:32];
            default:     rdata_d = '0;
         endcase
      end
   end

   // Architectural timer and software-interrupt state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msip     <= 1'b0;
         mtime    <= '0;
         mtimecmp <= MTIMECMP_RST;
      end else begin
         msip     <= msip_d;
         mtime    <= mtime_d;
         mtimecmp <= mtimecmp_d;
      end
   end

   // One-cycle response pulse for every accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bus_rvalid <= 1'b0;
         bus.bus_rdata  <= '0;
         bus.bus_err    <= 1'b0;
      end else begin
         bus.bus_rvalid <= bus.bus_valid;
         bus.bus_rdata  <= rdata_d;
         bus.bus_err    <= bus.bus_valid & ~addr_ok;
      end
   end

   // Interrupt levels: MTIP from registered compare, MSIP follows msip with the write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_interrupt    <= 1'b0;
         software_interrupt <= 1'b0;
      end else begin
         timer_interrupt    <= (mtime >= mtimecmp);
         software_interrupt <= msip_d;
      end
   end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: a PRESCALE=1 instance carries most of the
// traffic, a PRESCALE=4 instance checks the divided mtime rate.
module tb_clint_timer;

   localparam logic [15:0] A_MSIP   = 16'h0000;
   localparam logic [15:0] A_CMP_LO = 16'h4000;
   localparam logic [15:0] A_CMP_HI = 16'h4004;
   localparam logic [15:0] A_TM_LO  = 16'hBFF8;
   localparam logic [15:0] A_TM_HI  = 16'hBFFC;

   logic clk;
   logic rst_n;
   logic tmr_irq;
   logic sw_irq;
   logic tmr4_irq;
   logic sw4_irq;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard: expected responses in request order
   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   string       tag_q[$];

   clint_timer_if bif();
   clint_timer_if bif4();

   clint_timer #(.PRESCALE(1), .PRESCALE_W(16)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .bus                (bif),
      .timer_interrupt    (tmr_irq),
      .software_interrupt (sw_irq)
   );

   clint_timer #(.PRESCALE(4), .PRESCALE_W(16)) dut4 (
      .clk                (clk),
      .rst_n              (rst_n),
      .bus                (bif4),
      .timer_interrupt    (tmr4_irq),
      .software_interrupt (sw4_irq)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Idle cycles; returns #1 after the last edge
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one request for one cycle and queue its expected response
   task automatic access(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic exp_err, input logic [31:0] exp_rdata);
      bif.bus_valid = 1'b1;
      bif.bus_write = wr;
      bif.bus_addr  = addr;
      bif.bus_wdata = wdata;
      bif.bus_wstrb = wstrb;
      exp_q.push_back(exp_rdata);
      exp_err_q.push_back(exp_err);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      bif.bus_valid = 1'b0;
      bif.bus_write = 1'b0;
      bif.bus_wstrb = 4'h0;
   endtask

   task automatic rd(input string tag, input logic [15:0] addr, input logic [31:0] exp_rdata);
      access(tag, 1'b0, addr, 32'h0, 4'h0, 1'b0, exp_rdata);
   endtask

   task automatic wr(input string tag, input logic [15:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb);
      access(tag, 1'b1, addr, wdata, wstrb, 1'b0, 32'h0);
   endtask

   // Response monitor: sampled mid-cycle, each pulse consumes one expectation
   always @(negedge clk) begin
      if (rst_n && bif.bus_rvalid) begin
         if (exp_q.size() == 0) begin
            check_val("stray_rvalid", 64'(bif.bus_rvalid), 64'd0);
         end else begin
            string t;
            logic [31:0] e_d;
            logic        e_e;
            t   = tag_q.pop_front();
            e_d = exp_q.pop_front();
            e_e = exp_err_q.pop_front();
            check_val({t, "_rdata"}, 64'(bif.bus_rdata), 64'(e_d));
            check_val({t, "_err"}, 64'(bif.bus_err), 64'(e_e));
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bif.bus_valid  = 1'b0;
      bif.bus_write  = 1'b0;
      bif.bus_addr   = 16'h0;
      bif.bus_wdata  = 32'h0;
      bif.bus_wstrb  = 4'h0;
      bif4.bus_valid = 1'b0;
      bif4.bus_write = 1'b0;
      bif4.bus_addr  = 16'h0;
      bif4.bus_wdata = 32'h0;
      bif4.bus_wstrb = 4'h0;

      // Reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_rvalid", 64'(bif.bus_rvalid), 64'd0);
      check_val("rst_tmr", 64'(tmr_irq), 64'd0);
      check_val("rst_sw", 64'(sw_irq), 64'd0);
      rst_n = 1'b1;

      // Edge 1: mtimecmp reset value
      rd("cmp_hi_rst", A_CMP_HI, 32'hFFFF_FFFF);
      check_val("ready", 64'(bif.bus_ready), 64'd1);
      check_val("tmr_after_rst", 64'(tmr_irq), 64'd0);

      // Edges 2..39 idle, read at edge 40 returns count after edge 39
      idle(38);
      bif4.bus_valid = 1'b1;
      bif4.bus_addr  = A_TM_LO;
      rd("mtime_p1", A_TM_LO, 32'd39);
      check_val("p4_rvalid0", 64'(bif4.bus_rvalid), 64'd1);
      check_val("p4_mtime0", 64'(bif4.bus_rdata), 64'd9);
      idle(1);
      check_val("p4_rvalid1", 64'(bif4.bus_rvalid), 64'd1);
      check_val("p4_mtime1", 64'(bif4.bus_rdata), 64'd10);
      bif4.bus_valid = 1'b0;

      // Timer compare: mtime=0 at edge A, cmp=20 from edge A+2
      wr("mtime_lo_0", A_TM_LO, 32'h0, 4'hF);
      wr("cmp_hi_0", A_CMP_HI, 32'h0, 4'hF);
      wr("cmp_lo_20", A_CMP_LO, 32'd20, 4'hF);
      idle(18);
      check_val("tmr_before", 64'(tmr_irq), 64'd0);
      idle(1);
      check_val("tmr_rise", 64'(tmr_irq), 64'd1);
      rd("mtime_after_wr", A_TM_LO, 32'd21);
      wr("cmp_lo_max", A_CMP_LO, 32'hFFFF_FFFF, 4'hF);
      check_val("tmr_hold", 64'(tmr_irq), 64'd1);
      idle(1);
      check_val("tmr_fall", 64'(tmr_irq), 64'd0);

      // Byte strobes
      wr("cmp_lo_strb", A_CMP_LO, 32'h0000_AB00, 4'b0010);
      rd("cmp_lo_strb_rd", A_CMP_LO, 32'hFFFF_ABFF);
      rd("cmp_hi_rd", A_CMP_HI, 32'h0);

      // mtime wrap
      wr("mtime_hi_max", A_TM_HI, 32'hFFFF_FFFF, 4'hF);
      wr("mtime_lo_max", A_TM_LO, 32'hFFFF_FFFE, 4'hF);
      idle(2);
      check_val("tmr_at_max", 64'(tmr_irq), 64'd1);
      rd("mtime_hi_wrap", A_TM_HI, 32'h0);
      check_val("tmr_after_wrap", 64'(tmr_irq), 64'd0);
      rd("mtime_lo_wrap", A_TM_LO, 32'd1);

      idle($urandom_range(0, 5));

      // MSIP
      wr("msip_set", A_MSIP, 32'h3, 4'hF);
      check_val("sw_set", 64'(sw_irq), 64'd1);
      rd("msip_rd1", A_MSIP, 32'h1);
      wr("msip_clr", A_MSIP, 32'h0, 4'hF);
      check_val("sw_clr", 64'(sw_irq), 64'd0);
      wr("msip_set2", A_MSIP, 32'h1, 4'hF);
      wr("msip_nostrb", A_MSIP, 32'h0, 4'h0);
      check_val("sw_nostrb", 64'(sw_irq), 64'd1);
      rd("msip_rd2", A_MSIP, 32'h1);

      // Error responses
      access("err_unmapped", 1'b0, 16'h0008, 32'h0, 4'h0, 1'b1, 32'h0);
      access("err_misalign", 1'b0, 16'h4002, 32'h0, 4'h0, 1'b1, 32'h0);
      access("err_wr_misalign", 1'b1, 16'h4001, 32'h0, 4'hF, 1'b1, 32'h0);
      access("err_wr_unmapped", 1'b1, 16'h4008, 32'h0, 4'hF, 1'b1, 32'h0);
      rd("cmp_lo_intact", A_CMP_LO, 32'hFFFF_ABFF);

      // Reset in the middle of a transaction
      wr("cmp_lo_zero", A_CMP_LO, 32'h0, 4'hF);
      idle(2);
      check_val("tmr_pre_rst", 64'(tmr_irq), 64'd1);
      check_val("sw_pre_rst", 64'(sw_irq), 64'd1);
      bif.bus_valid = 1'b1;
      bif.bus_write = 1'b0;
      bif.bus_addr  = A_TM_LO;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bif.bus_valid = 1'b0;
      #1;
      check_val("mid_rst_rvalid", 64'(bif.bus_rvalid), 64'd0);
      check_val("mid_rst_rdata", 64'(bif.bus_rdata), 64'd0);
      check_val("mid_rst_tmr", 64'(tmr_irq), 64'd0);
      check_val("mid_rst_sw", 64'(sw_irq), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);
      rd("mtime_post_rst", A_TM_LO, 32'd3);
      rd("cmp_hi_post_rst", A_CMP_HI, 32'hFFFF_FFFF);
      rd("msip_post_rst", A_MSIP, 32'h0);
      check_val("tmr_post_rst", 64'(tmr_irq), 64'd0);

      // Drain and report
      @(negedge clk);
      #1;
      check_val("pending_rsp", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped core-local interruptor: owns machine timer (mtime/mtimecmp) and software-interrupt register (msip).
- Drives the timer_interrupt and software_interrupt inputs of the CSR file; those inputs feed mip.MTIP and mip.MSIP.
- Sits on the core's data-memory bus as a slave, decoded by the top level from a 64 KiB window.

Parameters:
- PRESCALE, 1, clk cycles per mtime increment (1 = every cycle); must be >= 1.
- PRESCALE_W, 16, width of prescaler counter; PRESCALE-1 must fit.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- bus_valid  input  1  request present this cycle
- bus_write  input  1  1 = write, 0 = read
- bus_addr  input  16  byte offset within CLINT window, word-aligned
- bus_wdata  input  32  write data
- bus_wstrb  input  4  byte enables for writes
- bus_ready  output  1  request accepted (always 1; no stall)
- bus_rdata  output  32  read data, valid when bus_rvalid
- bus_rvalid  output  1  read response strobe
- bus_err  output  1  unmapped or misaligned access response
- timer_interrupt  output  1  MTIP level to CSR file
- software_interrupt  output  1  MSIP level to CSR file

Behaviour:
- Register map (byte offsets): MSIP 0x0000 (bit0 only, rest read 0); MTIMECMP_LO 0x4000; MTIMECMP_HI 0x4004; MTIME_LO 0xBFF8; MTIME_HI 0xBFFC.
- Reset values: msip=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, bus_rdata=0, bus_rvalid=0, bus_err=0, timer_interrupt=0, software_interrupt=0.
- Handshake: bus_ready tied 1. Every request with bus_valid=1 is accepted in that cycle.
- Read latency: exactly 1 cycle. bus_rvalid=1 and bus_rdata are registered in the cycle after acceptance.
- Write response: bus_rvalid=1 with rdata=0 in the cycle after acceptance.
- bus_rvalid is a single-cycle pulse per accepted request.
- Error handling:
  - bus_addr[1:0]!=0 or an unmapped offset -> bus_err=1 alongside bus_rvalid, rdata=0, no state change.
- Byte strobes: writes honour bus_wstrb per byte. Strobe 4'b0000 is a no-op but still responds.
- Prescaler:
  - Counts 0..PRESCALE-1; tick when count==PRESCALE-1, then reset to 0.
  - With PRESCALE=1, tick every cycle.
- mtime:
  - Increments by 1 on tick, full 64-bit add.
  - Wraps from 2^64-1 to 0 with no side effects.
- Write vs increment:
  - A bus write to MTIME_LO or MTIME_HI in the same cycle as a tick takes priority over the increment for the whole 64-bit value: written half updates, other half holds, no increment that cycle.
  - Prescaler still advances normally.
- No atomic 64-bit read. Software uses a hi-lo-hi sequence.
- Read of MTIME_* returns the mtime value before that cycle's update.
- MSIP: software_interrupt is a registered copy of msip[0], updated the cycle after the write. Latency 1 cycle from write acceptance to output.
- Timer compare:
  - timer_interrupt <= (mtime >= mtimecmp), unsigned 64-bit, evaluated every cycle on registered values. Output lags state changes by 1 cycle.
  - Level output: it clears only when software raises mtimecmp above mtime or writes mtime below mtimecmp.
  - No self-clear on read.
- Reset mid-operation: asynchronous assertion forces all registers and outputs to reset values immediately. Any pending response is dropped (no bus_rvalid after reset release).
- Simultaneous read and state update: reads return pre-update values.

Decomposition:
- Shared package / include: CLINT register offsets (MSIP, MTIMECMP_LO/HI, MTIME_LO/HI), mtimecmp reset constant, window size constant.
- Interrupt cause constants (MTI=7, MSI=3, with the interrupt bit set) also go there for the trap logic.
- One natural sub-module: clint_prescaler (PRESCALE counter producing a 1-cycle tick). Everything else stays in clint_timer.

Test Plan:
- Reset release, read MTIMECMP_HI -> bus_rvalid 1 cycle later, rdata=32'hFFFF_FFFF, bus_err=0, timer_interrupt=0.
- PRESCALE=4, run 40 cycles after reset, read MTIME_LO -> rdata=10 (±1 per read-timing rule); with PRESCALE=1 over 40 cycles -> 40.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20 with PRESCALE=1 -> timer_interrupt rises exactly 1 cycle after mtime reaches 20. Then write MTIMECMP_LO=32'hFFFF_FFFF -> timer_interrupt falls 2 cycles after write acceptance.
- Write MTIME_HI=32'hFFFF_FFFF, MTIME_LO=32'hFFFF_FFFE -> after 2 ticks read MTIME_HI=0, MTIME_LO=0; wrap causes no bus_err.
- Write MSIP=32'h0000_0003 -> software_interrupt=1 next cycle, read MSIP returns 1. Write 0 -> clears next cycle. Write with wstrb=0 -> no change.
- Read 0x0008 and 0x4002 -> bus_err=1, rdata=0. Assert rst_n low mid-count -> mtime=0, outputs 0 immediately, no stray bus_rvalid after release.
